// File: rtl/clkdiv_sched_pkg.sv
// Shared types and ratio helpers for the clkdiv_sched controller.
// Define CLKDIV_SCHED_ODD_EN to make odd ratios (>=3) legal.
package clkdiv_sched_pkg;

  localparam int MAX_DIV_DEF = 256;
  localparam int DIV_W_DEF   = $clog2(MAX_DIV_DEF + 1);

  typedef enum logic [1:0] {STOP, RUN, PEND, DRAIN} state_t;

  function automatic bit is_legal_div(int d, int max_div);
`ifdef CLKDIV_SCHED_ODD_EN
    return (d >= 2) && (d <= max_div);
`else
    return (d >= 2) && (d <= max_div) && (d[0] == 1'b0);
`endif
  endfunction

  // The extra cycle of an odd ratio goes to the high phase.
  function automatic int hi_len(int d);
`ifdef CLKDIV_SCHED_ODD_EN
    return (d + 1) / 2;
`else
    return d / 2;
`endif
  endfunction

  function automatic int lo_len(int d);
    return d / 2;
  endfunction

endpackage

// File: rtl/clkdiv_sched_if.sv
// Ratio configuration port: valid/ready handshake carrying a new divide ratio.
interface clkdiv_sched_if #(
  parameter int DIV_W = clkdiv_sched_pkg::DIV_W_DEF
);
  logic             cfg_valid;
  logic [DIV_W-1:0] cfg_div;
  logic             cfg_ready;

  modport master (output cfg_valid, output cfg_div, input cfg_ready);
  modport slave  (input cfg_valid, input cfg_div, output cfg_ready);
endinterface

// File: rtl/clkdiv_sched_core.sv
// Phase counter and clk_div register; phase lengths latched on load.
// Honours CLKDIV_SCHED_ODD_EN through the package length helpers.
module clkdiv_core
  import clkdiv_sched_pkg::*;
#(
  parameter int DIV_W       = DIV_W_DEF,
  parameter int DEFAULT_DIV = 6
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             run,
  input  logic             load,
  input  logic [DIV_W-1:0] div,
  output logic             boundary,
  output logic             clk_div
);

  logic [DIV_W-1:0] cnt_reg;
  logic [DIV_W-1:0] hi_len_reg;
  logic [DIV_W-1:0] lo_len_reg;
  logic             clk_div_reg;
  logic [DIV_W-1:0] phase_last;

  assign phase_last = (clk_div_reg ? hi_len_reg : lo_len_reg) - DIV_W'(1);
  // Boundary is ungated by run so the scheduler can see it while stopping.
  assign boundary   = clk_div_reg && (cnt_reg == phase_last);
  assign clk_div    = clk_div_reg;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cnt_reg     <= '0;
      clk_div_reg <= 1'b0;
      hi_len_reg  <= DIV_W'(hi_len(DEFAULT_DIV));
      lo_len_reg  <= DIV_W'(lo_len(DEFAULT_DIV));
    end else begin
      if (load) begin
        hi_len_reg <= DIV_W'(hi_len(int'(div)));
        lo_len_reg <= DIV_W'(lo_len(int'(div)));
      end
      if (!run) begin
        cnt_reg     <= '0;
        clk_div_reg <= 1'b0;
      end else if (cnt_reg == phase_last) begin
        cnt_reg     <= '0;
        clk_div_reg <= ~clk_div_reg;
      end else begin
        cnt_reg <= cnt_reg + DIV_W'(1);
      end
    end
  end

endmodule

// File: rtl/clkdiv_sched.sv
// Divided-clock scheduler: ratio handshake, pending ratio, glitch-free start/stop.
// Odd ratios are accepted only when CLKDIV_SCHED_ODD_EN is defined.
module clkdiv_sched
  import clkdiv_sched_pkg::*;
#(
  parameter int MAX_DIV     = 256,
  parameter int DIV_W       = $clog2(MAX_DIV + 1),
  parameter int DEFAULT_DIV = 6
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             en,
  clkdiv_sched_if.slave    cfg,
  output logic             clk_div,
  output logic             div_tick,
  output logic [DIV_W-1:0] cur_div,
  output logic             busy,
  output logic             cfg_err
);

  state_t           state_reg, state_next;
  logic [DIV_W-1:0] cur_div_reg, cur_div_next;
  logic [DIV_W-1:0] pend_reg, pend_next;
  logic             pend_valid_reg, pend_valid_next;
  logic             cfg_ready_reg, div_tick_reg, cfg_err_reg, busy_reg;
  logic             xfer, xfer_legal, boundary, core_clk_div, core_run, core_load;

  assign xfer       = cfg.cfg_valid && cfg_ready_reg;
  assign xfer_legal = xfer && is_legal_div(int'(cfg.cfg_div), MAX_DIV);

  always_comb begin
    state_next      = state_reg;
    cur_div_next    = cur_div_reg;
    pend_next       = pend_reg;
    pend_valid_next = pend_valid_reg;
    core_load       = 1'b0;
    case (state_reg)
      STOP: begin
        if (xfer_legal) begin
          cur_div_next = cfg.cfg_div;
          core_load    = 1'b1;
        end
        if (en) state_next = RUN;
      end
      default: begin
        // Either a period ends now, or we can stop cleanly in the low phase.
        if (boundary || (!en && !core_clk_div)) begin
          if (pend_valid_reg) begin
            cur_div_next    = pend_reg;
            core_load       = 1'b1;
            pend_valid_next = 1'b0;
          end
          state_next = en ? RUN : STOP;
        end else if (!en) begin
          state_next = DRAIN;
        end else begin
          state_next = pend_valid_reg ? PEND : RUN;
        end
        // A ratio arriving on a boundary waits for the following one.
        if (xfer_legal) begin
          if (state_next == STOP) begin
            cur_div_next = cfg.cfg_div;
            core_load    = 1'b1;
          end else begin
            pend_next       = cfg.cfg_div;
            pend_valid_next = 1'b1;
            if (state_next == RUN) state_next = PEND;
          end
        end
      end
    endcase
    core_run = (state_reg != STOP) && (state_next != STOP);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_reg      <= STOP;
      cur_div_reg    <= DIV_W'(DEFAULT_DIV);
      pend_reg       <= '0;
      pend_valid_reg <= 1'b0;
      cfg_ready_reg  <= 1'b1;
      div_tick_reg   <= 1'b0;
      cfg_err_reg    <= 1'b0;
      busy_reg       <= 1'b0;
    end else begin
      state_reg      <= state_next;
      cur_div_reg    <= cur_div_next;
      pend_reg       <= pend_next;
      pend_valid_reg <= pend_valid_next;
      cfg_ready_reg  <= (state_next == STOP) || (state_next == RUN);
      div_tick_reg   <= boundary;
      cfg_err_reg    <= xfer && !xfer_legal;
      busy_reg       <= (state_next != STOP);
    end
  end

  clkdiv_core #(
    .DIV_W      (DIV_W),
    .DEFAULT_DIV(DEFAULT_DIV)
  ) u_core (
    .clk     (clk),
    .reset_n (reset_n),
    .run     (core_run),
    .load    (core_load),
    .div     (cur_div_next),
    .boundary(boundary),
    .clk_div (core_clk_div)
  );

  assign cfg.cfg_ready = cfg_ready_reg;
  assign clk_div       = core_clk_div;
  assign div_tick      = div_tick_reg;
  assign cur_div       = cur_div_reg;
  assign busy          = busy_reg;
  assign cfg_err       = cfg_err_reg;

endmodule

// File: tb/tb_clkdiv_sched.sv
// Bench for clkdiv_sched: directed sequences, ratio table, randomized run vs period model.
// Expectations follow CLKDIV_SCHED_ODD_EN when the bench is built with it.
module tb_clkdiv_sched;

  localparam int DIV_W = 9;
`ifdef CLKDIV_SCHED_ODD_EN
  localparam bit ODD_EN = 1'b1;
`else
  localparam bit ODD_EN = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             reset_n = 1'b0;
  logic             en = 1'b0;
  logic             clk_div, div_tick, busy, cfg_err;
  logic [DIV_W-1:0] cur_div;

  int n_tests = 0;
  int n_fail  = 0;

  clkdiv_sched_if #(.DIV_W(DIV_W)) cfg_if ();

  clkdiv_sched dut (
    .clk     (clk),
    .reset_n (reset_n),
    .en      (en),
    .cfg     (cfg_if),
    .clk_div (clk_div),
    .div_tick(div_tick),
    .cur_div (cur_div),
    .busy    (busy),
    .cfg_err (cfg_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int div;
    bit err;
    int cur;
    int lo;
    int hi;
  } vec_t;

  vec_t vecs[9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    en = 1'b0;
    cfg_if.cfg_valid = 1'b0;
    cfg_if.cfg_div = '0;
    step();
    step();
    reset_n = 1'b1;
  endtask

  // Called at the start of a low phase; measures one low and one high phase.
  task automatic measure_period(output int lo, output int hi, output bit tick_ok);
    int n;
    n = 0;
    tick_ok = 1'b1;
    while (clk_div !== 1'b1 && n < 600) begin
      step();
      n++;
      if (div_tick !== 1'b0) tick_ok = 1'b0;
    end
    lo = n;
    while (clk_div !== 1'b0 && n < 1200) begin
      step();
      n++;
      if (div_tick !== (clk_div === 1'b0)) tick_ok = 1'b0;
    end
    hi = n - lo;
  endtask

  function automatic bit model_legal(int d);
    return (d >= 2) && (d <= 256) && (ODD_EN || (d % 2 == 0));
  endfunction

  initial begin
    int lo, hi;
    bit tk;
    int d_m, pos_m, pend_m, offer;
    bit pv_m, tick_m, err_m, xf;
    int pool[12];

    vecs[0] = '{8,   1'b0,    8,                 4,   4};
    vecs[1] = '{5,   !ODD_EN, (ODD_EN ? 5 : 8),  2,   3};
    vecs[2] = '{0,   1'b1,    (ODD_EN ? 5 : 8),  0,   0};
    vecs[3] = '{1,   1'b1,    (ODD_EN ? 5 : 8),  0,   0};
    vecs[4] = '{257, 1'b1,    (ODD_EN ? 5 : 8),  0,   0};
    vecs[5] = '{256, 1'b0,    256,               128, 128};
    vecs[6] = '{2,   1'b0,    2,                 1,   1};
    vecs[7] = '{7,   !ODD_EN, (ODD_EN ? 7 : 2),  3,   4};
    vecs[8] = '{6,   1'b0,    6,                 3,   3};
    pool = '{2, 3, 4, 5, 6, 8, 10, 12, 0, 1, 257, 256};

    // Reset values
    do_reset();
    check("rst clk_div", clk_div, 0);
    check("rst div_tick", div_tick, 0);
    check("rst cfg_err", cfg_err, 0);
    check("rst busy", busy, 0);
    check("rst cfg_ready", cfg_if.cfg_ready, 1);
    check("rst cur_div", cur_div, 6);

    // Start with D=6
    en = 1'b1;
    step();
    check("start busy", busy, 1);
    check("start clk_div", clk_div, 0);
    measure_period(lo, hi, tk);
    check("d6 first lo", lo, 3);
    check("d6 first hi", hi, 3);
    check("d6 first tick", tk, 1);
    measure_period(lo, hi, tk);
    check("d6 second lo", lo, 3);
    check("d6 second hi", hi, 3);
    $display("[TB] start D=6: lo=%0d hi=%0d", lo, hi);

    // Change to D=4 offered in the high phase
    repeat (4) step();
    check("chg in high", clk_div, 1);
    cfg_if.cfg_valid = 1'b1;
    cfg_if.cfg_div = 9'd4;
    step();
    cfg_if.cfg_valid = 1'b0;
    check("chg ready low", cfg_if.cfg_ready, 0);
    check("chg cur old", cur_div, 6);
    check("chg still high", clk_div, 1);
    step();
    check("chg bnd clk_div", clk_div, 0);
    check("chg bnd tick", div_tick, 1);
    check("chg bnd cur_div", cur_div, 4);
    check("chg bnd ready", cfg_if.cfg_ready, 1);
    measure_period(lo, hi, tk);
    check("d4 lo", lo, 2);
    check("d4 hi", hi, 2);
    check("d4 tick", tk, 1);
    $display("[TB] change to D=4: lo=%0d hi=%0d", lo, hi);

    // en=0 in the high phase drains to the boundary
    step();
    step();
    check("drain pre high", clk_div, 1);
    en = 1'b0;
    step();
    check("drain busy", busy, 1);
    check("drain clk_div", clk_div, 1);
    check("drain ready", cfg_if.cfg_ready, 0);
    step();
    check("drain end clk_div", clk_div, 0);
    check("drain end tick", div_tick, 1);
    check("drain end busy", busy, 0);
    check("drain end ready", cfg_if.cfg_ready, 1);
    $display("[TB] drain from high phase");

    // en=0 in the low phase stops on the next edge
    en = 1'b1;
    step();
    step();
    en = 1'b0;
    step();
    check("lowstop clk_div", clk_div, 0);
    check("lowstop busy", busy, 0);
    check("lowstop tick", div_tick, 0);
    $display("[TB] stop from low phase");

    // Ratio table applied while stopped
    foreach (vecs[i]) begin
      cfg_if.cfg_valid = 1'b1;
      cfg_if.cfg_div = vecs[i].div[DIV_W-1:0];
      step();
      cfg_if.cfg_valid = 1'b0;
      check($sformatf("vec%0d cfg_err", i), cfg_err, vecs[i].err);
      check($sformatf("vec%0d cur_div", i), cur_div, vecs[i].cur);
      step();
      check($sformatf("vec%0d err pulse", i), cfg_err, 0);
      if (!vecs[i].err) begin
        en = 1'b1;
        step();
        measure_period(lo, hi, tk);
        check($sformatf("vec%0d lo", i), lo, vecs[i].lo);
        check($sformatf("vec%0d hi", i), hi, vecs[i].hi);
        check($sformatf("vec%0d tick", i), tk, 1);
        en = 1'b0;
        step();
        check($sformatf("vec%0d stop", i), busy, 0);
      end
      $display("[TB] vec %0d: div=%0d err=%0d cur=%0d lo=%0d hi=%0d",
               i, vecs[i].div, cfg_err, cur_div, lo, hi);
    end

    // Reset while a ratio is pending
    do_reset();
    en = 1'b1;
    step();
    cfg_if.cfg_valid = 1'b1;
    cfg_if.cfg_div = 9'd4;
    step();
    cfg_if.cfg_valid = 1'b0;
    check("pend ready", cfg_if.cfg_ready, 0);
    reset_n = 1'b0;
    step();
    reset_n = 1'b1;
    check("pendrst clk_div", clk_div, 0);
    check("pendrst cur_div", cur_div, 6);
    check("pendrst busy", busy, 0);
    check("pendrst ready", cfg_if.cfg_ready, 1);
    step();
    measure_period(lo, hi, tk);
    check("pendrst lo1", lo, 3);
    check("pendrst hi1", hi, 3);
    measure_period(lo, hi, tk);
    check("pendrst lo2", lo, 3);
    check("pendrst hi2", hi, 3);
    check("pendrst cur after", cur_div, 6);
    $display("[TB] reset during pending: lo=%0d hi=%0d cur=%0d", lo, hi, cur_div);

    // Randomized ratio offers while running, against a period model
    do_reset();
    en = 1'b1;
    step();
    d_m = 6; pos_m = 0; pv_m = 1'b0; tick_m = 1'b0; err_m = 1'b0; pend_m = 0;
    for (int c = 0; c < 4000; c++) begin
      check($sformatf("rand@%0d {clk,tick,err,ready,busy,cur}", c),
            {clk_div, div_tick, cfg_err, cfg_if.cfg_ready, busy, cur_div},
            {(pos_m >= d_m / 2), tick_m, err_m, !pv_m, 1'b1, 9'(d_m)});
      cfg_if.cfg_valid = ($urandom_range(0, 2) == 0);
      offer = pool[$urandom_range(0, 11)];
      cfg_if.cfg_div = offer[DIV_W-1:0];
      xf = cfg_if.cfg_valid && !pv_m;
      step();
      pos_m++;
      tick_m = 1'b0;
      if (pos_m == d_m) begin
        pos_m = 0;
        tick_m = 1'b1;
        if (pv_m) begin
          d_m = pend_m;
          pv_m = 1'b0;
        end
      end
      err_m = xf && !model_legal(offer);
      if (xf && model_legal(offer)) begin
        pend_m = offer;
        pv_m = 1'b1;
      end
      if (xf) $display("[TB] rand xfer @%0d div=%0d legal=%0d", c, offer, model_legal(offer));
    end
    cfg_if.cfg_valid = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
